// File: rtl/ptcalc_dispatcher.sv
// ptcalc_dispatcher
// Hands each valid SLC candidate to a free pT-calculation block using a
// round-robin search. It remembers the muon ID each busy block is working on
// and frees the block when the matching pT result comes back or when the
// block has been outstanding too long. Every candidate is also forwarded to
// the SLC pipeline that feeds the MTC builder. That copy is tagged busy when
// no block could take the candidate.
module ptcalc_dispatcher #(
   parameter int SLC_WIDTH         = 32,
   parameter int PTCALC_WIDTH      = 16,
   parameter int TOTAL_PTCALC_BLKS = 3,
   parameter int MUID_LEN          = 8,
   parameter int SLC_MUID_LSB      = 0,
   parameter int PT_MUID_LSB       = 0,
   parameter int TIMEOUT           = 1024
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            srst,
   input  logic [SLC_WIDTH:0]                              slc_in,
   input  logic [TOTAL_PTCALC_BLKS-1:0][PTCALC_WIDTH:0]    ptcalc_res,
   output logic [TOTAL_PTCALC_BLKS-1:0][SLC_WIDTH:0]       slc_to_pt,
   output logic [SLC_WIDTH:0]                              slcpipe_out,
   output logic                                            busy_out,
   output logic [TOTAL_PTCALC_BLKS-1:0]                    blk_busy,
   output logic [TOTAL_PTCALC_BLKS-1:0]                    timeout_pulse,
   output logic                                            muid_err
);

   localparam int NB = TOTAL_PTCALC_BLKS;
   localparam int PW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic {
      BLK_IDLE = 1'b0,
      BLK_BUSY = 1'b1
   } blk_state_e;

   blk_state_e                       state_q [NB];
   blk_state_e                       state_d [NB];
   logic [MUID_LEN-1:0]              muid_q  [NB];
   logic [MUID_LEN-1:0]              muid_d  [NB];
   logic [15:0]                      cnt_q   [NB];
   logic [15:0]                      cnt_d   [NB];
   logic [NB-1:0]                    armed_q, armed_d;
   logic [PW-1:0]                    rr_ptr_q, rr_ptr_d;
   logic [NB-1:0][SLC_WIDTH:0]       slc_to_pt_q, slc_to_pt_d;
   logic [SLC_WIDTH:0]               slcpipe_q, slcpipe_d;
   logic                             busy_q, busy_d;
   logic [NB-1:0]                    timeout_q, timeout_d;
   logic                             muid_err_q, muid_err_d;

   logic                             found;
   logic [PW-1:0]                    sel;
   logic [PW:0]                      cand;
   logic                             unused_res;

   // Only the valid bit and the muid field of each pT result are looked at.
   assign unused_res = ^ptcalc_res;

   // Round-robin search for the first idle block at or after rr_ptr, wrapping.
   // It uses the registered state, so a block freed on this edge is not eligible.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NB; k++) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NB)) begin
            cand = cand - (PW+1)'(NB);
         end
         if (!found && state_q[cand[PW-1:0]] == BLK_IDLE) begin
            found = 1'b1;
            sel   = cand[PW-1:0];
         end
      end
   end

   // Next state for each block: result matching, timeout, error flagging and dispatch.
   // "armed" means the block has been dispatched since reset. A result that lands
   // on an idle block that was never armed is a leftover from before the reset,
   // so it is ignored and does not raise muid_err.
   always_comb begin
      muid_err_d = muid_err_q;
      timeout_d  = '0;
      armed_d    = armed_q;
      for (int p = 0; p < NB; p++) begin
         state_d[p] = state_q[p];
         muid_d[p]  = muid_q[p];
         cnt_d[p]   = cnt_q[p];
         if (state_q[p] == BLK_BUSY) begin
            if (cnt_q[p] != 16'hFFFF) begin
               cnt_d[p] = cnt_q[p] + 16'd1;
            end
            if (ptcalc_res[p][PTCALC_WIDTH] &&
                ptcalc_res[p][PT_MUID_LSB +: MUID_LEN] == muid_q[p]) begin
               state_d[p] = BLK_IDLE;
            end else begin
               if (ptcalc_res[p][PTCALC_WIDTH]) begin
                  muid_err_d = 1'b1;
               end
               if (cnt_q[p] == TO_LAST) begin
                  state_d[p]   = BLK_IDLE;
                  timeout_d[p] = 1'b1;
               end
            end
         end else begin
            if (ptcalc_res[p][PTCALC_WIDTH] && armed_q[p]) begin
               muid_err_d = 1'b1;
            end
            if (slc_in[SLC_WIDTH] && found && sel == PW'(p)) begin
               state_d[p] = BLK_BUSY;
               muid_d[p]  = slc_in[SLC_MUID_LSB +: MUID_LEN];
               cnt_d[p]   = '0;
               armed_d[p] = 1'b1;
            end
         end
      end
   end

   // Output data for the next cycle and the round-robin pointer advance.
   always_comb begin
      slc_to_pt_d = '0;
      slcpipe_d   = '0;
      busy_d      = 1'b0;
      rr_ptr_d    = rr_ptr_q;
      if (slc_in[SLC_WIDTH]) begin
         slcpipe_d = slc_in;
         if (found) begin
            slc_to_pt_d[sel] = slc_in;
            rr_ptr_d = (sel == PW'(NB - 1)) ? '0 : sel + 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end
   end

   // State register. The async reset wins, then the soft reset, then normal update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < NB; p++) begin
            state_q[p] <= BLK_IDLE;
            muid_q[p]  <= '0;
            cnt_q[p]   <= '0;
         end
         armed_q     <= '0;
         rr_ptr_q    <= '0;
         slc_to_pt_q <= '0;
         slcpipe_q   <= '0;
         busy_q      <= 1'b0;
         timeout_q   <= '0;
         muid_err_q  <= 1'b0;
      end else if (srst) begin
         for (int p = 0; p < NB; p++) begin
            state_q[p] <= BLK_IDLE;
            muid_q[p]  <= '0;
            cnt_q[p]   <= '0;
         end
         armed_q     <= '0;
         rr_ptr_q    <= '0;
         slc_to_pt_q <= '0;
         slcpipe_q   <= '0;
         busy_q      <= 1'b0;
         timeout_q   <= '0;
         muid_err_q  <= 1'b0;
      end else begin
         for (int p = 0; p < NB; p++) begin
            state_q[p] <= state_d[p];
            muid_q[p]  <= muid_d[p];
            cnt_q[p]   <= cnt_d[p];
         end
         armed_q     <= armed_d;
         rr_ptr_q    <= rr_ptr_d;
         slc_to_pt_q <= slc_to_pt_d;
         slcpipe_q   <= slcpipe_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         muid_err_q  <= muid_err_d;
      end
   end

   // Expose each block's registered IDLE/BUSY state as a flat flag vector.
   always_comb begin
      blk_busy = '0;
      for (int p = 0; p < NB; p++) begin
         blk_busy[p] = (state_q[p] == BLK_BUSY);
      end
   end

   assign slc_to_pt     = slc_to_pt_q;
   assign slcpipe_out   = slcpipe_q;
   assign busy_out      = busy_q;
   assign timeout_pulse = timeout_q;
   assign muid_err      = muid_err_q;

endmodule

// File: tb/tb_ptcalc_dispatcher.sv
// tb_ptcalc_dispatcher
// Directed scenarios followed by a randomized run. Every cycle, the DUT outputs
// are compared with a transaction-level reference model. The model tracks each
// block as "outstanding since cycle N" and finds timeouts from elapsed cycles.
module tb_ptcalc_dispatcher;

   localparam int SW      = 16;
   localparam int PWD     = 12;
   localparam int NB      = 3;
   localparam int ML      = 8;
   localparam int SLC_LSB = 4;
   localparam int PT_LSB  = 2;
   localparam int TMO     = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      srst;
   logic [SW:0]               slc_in;
   logic [NB-1:0][PWD:0]      ptcalc_res;
   logic [NB-1:0][SW:0]       slc_to_pt;
   logic [SW:0]               slcpipe_out;
   logic                      busy_out;
   logic [NB-1:0]             blk_busy;
   logic [NB-1:0]             timeout_pulse;
   logic                      muid_err;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit                  m_busy  [NB];
   bit                  m_armed [NB];
   logic [ML-1:0]       m_muid  [NB];
   int                  m_disp  [NB];
   int                  m_rr;
   bit                  m_err;
   int                  cyc;

   // expected outputs after the current edge
   logic [NB-1:0][SW:0] exp_slc_to_pt;
   logic [SW:0]         exp_pipe;
   logic                exp_busy;
   logic [NB-1:0]       exp_to;

   ptcalc_dispatcher #(
      .SLC_WIDTH(SW), .PTCALC_WIDTH(PWD), .TOTAL_PTCALC_BLKS(NB), .MUID_LEN(ML),
      .SLC_MUID_LSB(SLC_LSB), .PT_MUID_LSB(PT_LSB), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .srst(srst), .slc_in(slc_in), .ptcalc_res(ptcalc_res),
      .slc_to_pt(slc_to_pt), .slcpipe_out(slcpipe_out), .busy_out(busy_out),
      .blk_busy(blk_busy), .timeout_pulse(timeout_pulse), .muid_err(muid_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic modelReset();
      for (int p = 0; p < NB; p++) begin
         m_busy[p] = 0; m_armed[p] = 0; m_muid[p] = '0; m_disp[p] = 0;
      end
      m_rr = 0; m_err = 0;
      exp_slc_to_pt = '0; exp_pipe = '0; exp_busy = 1'b0; exp_to = '0;
   endtask

   // One clock edge of the reference model, using the inputs present at that edge.
   task automatic modelStep(input logic [SW:0] slc, input logic [NB-1:0][PWD:0] res,
                            input logic sr);
      int tgt;
      cyc++;
      if (!rst || sr) begin
         modelReset();
         return;
      end
      exp_slc_to_pt = '0; exp_pipe = '0; exp_busy = 1'b0; exp_to = '0;
      tgt = -1;
      if (slc[SW]) begin
         exp_pipe = slc;
         for (int k = 0; k < NB; k++) begin
            if (tgt < 0 && !m_busy[(m_rr + k) % NB]) tgt = (m_rr + k) % NB;
         end
         if (tgt >= 0) exp_slc_to_pt[tgt] = slc;
         else exp_busy = 1'b1;
      end
      for (int p = 0; p < NB; p++) begin
         if (m_busy[p]) begin
            if (res[p][PWD] && res[p][PT_LSB +: ML] == m_muid[p]) begin
               m_busy[p] = 0;
            end else begin
               if (res[p][PWD]) m_err = 1;
               if (cyc - m_disp[p] == TMO) begin
                  m_busy[p] = 0;
                  exp_to[p] = 1'b1;
               end
            end
         end else if (res[p][PWD] && m_armed[p]) begin
            m_err = 1;
         end
      end
      if (tgt >= 0) begin
         m_busy[tgt]  = 1;
         m_armed[tgt] = 1;
         m_muid[tgt]  = slc[SLC_LSB +: ML];
         m_disp[tgt]  = cyc;
         m_rr         = (tgt + 1) % NB;
      end
   endtask

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [NB-1:0] eb;
      for (int p = 0; p < NB; p++) eb[p] = m_busy[p];
      checkVal({tag, ".slc_to_pt"}, 64'(slc_to_pt), 64'(exp_slc_to_pt));
      checkVal({tag, ".slcpipe_out"}, 64'(slcpipe_out), 64'(exp_pipe));
      checkVal({tag, ".busy_out"}, 64'(busy_out), 64'(exp_busy));
      checkVal({tag, ".blk_busy"}, 64'(blk_busy), 64'(eb));
      checkVal({tag, ".timeout_pulse"}, 64'(timeout_pulse), 64'(exp_to));
      checkVal({tag, ".muid_err"}, 64'(muid_err), 64'(m_err));
   endtask

   // Drive the inputs, step through one edge, update the model and check 1 ns later.
   task automatic applyStimulus(input logic [SW:0] slc, input logic [NB-1:0][PWD:0] res,
                                input logic sr, input string tag);
      slc_in = slc; ptcalc_res = res; srst = sr;
      @(posedge clk);
      modelStep(slc, res, sr);
      #1;
      checkOutput(tag);
   endtask

   function automatic logic [SW:0] mkSlc(input logic [ML-1:0] muid);
      logic [SW:0] v;
      v = SW'($urandom);
      v[SLC_LSB +: ML] = muid;
      return {1'b1, v[SW-1:0]};
   endfunction

   function automatic logic [PWD:0] mkRes(input logic [ML-1:0] muid);
      logic [PWD:0] v;
      v = PWD'($urandom);
      v[PT_LSB +: ML] = muid;
      return {1'b1, v[PWD-1:0]};
   endfunction

   logic [NB-1:0][PWD:0] res;
   logic [NB-1:0][PWD:0] nores;
   logic [SW:0]          noslc;
   int                   pulse_cnt;
   int                   pulse_k;

   initial begin
      nores = '0; noslc = '0; cyc = 0;
      rst = 1'b0; srst = 1'b0; slc_in = '0; ptcalc_res = '0;
      modelReset();
      #1;
      applyStimulus(noslc, nores, 1'b0, "reset0");
      applyStimulus(noslc, nores, 1'b0, "reset1");
      rst = 1'b1;

      // three candidates fill blocks 0,1,2
      applyStimulus(mkSlc(8'h10), nores, 1'b0, "disp10");
      checkVal("disp10.blk0_valid", 64'(slc_to_pt[0][SW]), 64'd1);
      applyStimulus(mkSlc(8'h11), nores, 1'b0, "disp11");
      checkVal("disp11.blk1_valid", 64'(slc_to_pt[1][SW]), 64'd1);
      applyStimulus(mkSlc(8'h12), nores, 1'b0, "disp12");
      checkVal("disp12.blk2_valid", 64'(slc_to_pt[2][SW]), 64'd1);
      checkVal("full.blk_busy", 64'(blk_busy), 64'h7);

      // all busy: candidate forwarded with busy_out
      applyStimulus(mkSlc(8'h13), nores, 1'b0, "allbusy13");
      checkVal("allbusy13.busy_out", 64'(busy_out), 64'd1);

      // result frees block 1, next candidate goes there
      res = nores; res[1] = mkRes(8'h11);
      applyStimulus(noslc, res, 1'b0, "res11");
      applyStimulus(mkSlc(8'h14), nores, 1'b0, "disp14");
      checkVal("disp14.blk1_valid", 64'(slc_to_pt[1][SW]), 64'd1);

      // release and candidate on the same edge: the freed block is not eligible yet
      res = nores; res[0] = mkRes(8'h10);
      applyStimulus(mkSlc(8'h15), res, 1'b0, "relsame15");
      checkVal("relsame15.busy_out", 64'(busy_out), 64'd1);
      applyStimulus(mkSlc(8'h16), nores, 1'b0, "disp16");
      checkVal("disp16.blk0_valid", 64'(slc_to_pt[0][SW]), 64'd1);

      // timeout on block 2
      applyStimulus(noslc, nores, 1'b1, "srst");
      applyStimulus(mkSlc(8'h20), nores, 1'b0, "to_a");
      applyStimulus(mkSlc(8'h21), nores, 1'b0, "to_b");
      applyStimulus(mkSlc(8'h22), nores, 1'b0, "to_c");
      pulse_cnt = 0; pulse_k = 0;
      res = nores; res[0] = mkRes(8'h20); res[1] = mkRes(8'h21);
      applyStimulus(noslc, res, 1'b0, "to_k1");
      for (int k = 2; k <= 20; k++) begin
         applyStimulus(noslc, nores, 1'b0, "to_wait");
         if (timeout_pulse[2]) begin
            pulse_cnt++;
            pulse_k = k;
         end
      end
      checkVal("timeout.pulse_count", 64'(pulse_cnt), 64'd1);
      checkVal("timeout.pulse_cycle", 64'(pulse_k), 64'd16);
      checkVal("timeout.blk2_idle", 64'(blk_busy[2]), 64'd0);
      checkVal("timeout.no_err", 64'(muid_err), 64'd0);

      // muid mismatch is sticky and keeps the block busy
      applyStimulus(mkSlc(8'h10), nores, 1'b0, "err_disp");
      res = nores; res[0] = mkRes(8'h55);
      applyStimulus(noslc, res, 1'b0, "err_mismatch");
      checkVal("err_mismatch.muid_err", 64'(muid_err), 64'd1);
      checkVal("err_mismatch.blk0_busy", 64'(blk_busy[0]), 64'd1);
      res = nores; res[1] = mkRes(8'h33);
      applyStimulus(noslc, res, 1'b0, "err_idle");
      checkVal("err_idle.muid_err", 64'(muid_err), 64'd1);

      // async reset mid-cycle with two blocks busy
      applyStimulus(mkSlc(8'h31), nores, 1'b0, "pre_rst");
      #2;
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst");
      res = nores; res[0] = mkRes(8'h10);
      applyStimulus(noslc, res, 1'b0, "in_rst");
      rst = 1'b1;
      applyStimulus(noslc, res, 1'b0, "stale_res");
      applyStimulus(mkSlc(8'h40), nores, 1'b0, "post_rst");
      checkVal("post_rst.blk0_valid", 64'(slc_to_pt[0][SW]), 64'd1);

      // randomized traffic with periodic soft reset
      for (int i = 0; i < 400; i++) begin
         logic [SW:0] s;
         logic        sr;
         res = nores;
         for (int p = 0; p < NB; p++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (m_busy[p] && r < 8) res[p] = mkRes(m_muid[p]);
            else if (r >= 98) res[p] = mkRes(ML'($urandom));
         end
         s = SW'($urandom) | (SW+1)'(0);
         s[SW] = ($urandom_range(0, 1) == 1);
         if (s[SW]) s = mkSlc(ML'($urandom));
         sr = (i % 80 == 79);
         applyStimulus(s, res, sr, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ptcalc_dispatcher.md
Name: ptcalc_dispatcher

Overview:
- Upstream counterpart of the MTC builder. Takes the stream of SLC candidates and hands each one to a free pT-calculation block (round-robin across TOTAL_PTCALC_BLKS).
- Tracks the outstanding muon ID per block. Releases a block when its pT result returns or when it times out.
- Emits each candidate, tagged with a busy flag, to the SLC pipeline that feeds the MTC builder.

Parameters:
- SLC_WIDTH, SLCPIPE_MTC_BARREL_LEN: candidate payload width; bit [SLC_WIDTH] of every bus is the valid bit.
- PTCALC_WIDTH, PTCALC_LEN: pT result payload width; bit [PTCALC_WIDTH] is the valid bit.
- TOTAL_PTCALC_BLKS, 3: number of pT-calc blocks (1..8).
- MUID_LEN, SLC_MUID_LEN: width of the muon ID field.
- SLC_MUID_LSB, SLCPIPE_MTC_BARREL_SLC_MUID_LSB: muid lsb inside the candidate.
- PT_MUID_LSB, PTCALC_SLC_MUID_LSB: muid lsb inside the pT result.
- TIMEOUT, 1024: cycles a block may stay outstanding; 16-bit counter.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- srst, in, 1: synchronous, active-high soft reset; same effect as rst.
- slc_in, in, SLC_WIDTH+1: candidate, valid in the MSB.
- ptcalc_res, in, (PTCALC_WIDTH+1) x TOTAL_PTCALC_BLKS: pT results from the blocks, valid in the MSB.
- slc_to_pt, out, (SLC_WIDTH+1) x TOTAL_PTCALC_BLKS: candidate dispatched to block p.
- slcpipe_out, out, SLC_WIDTH+1: candidate forwarded to the SLC pipeline.
- busy_out, out, 1: qualifies slcpipe_out; 1 means no pT-calc block accepted the candidate.
- blk_busy, out, TOTAL_PTCALC_BLKS: per-block outstanding flags.
- timeout_pulse, out, TOTAL_PTCALC_BLKS: one-cycle pulse when a block is released by timeout.
- muid_err, out, 1: sticky flag; set when a result muid mismatches the stored muid, or a result arrives on an idle block.

Behaviour:
- Reset (rst low, or srst high): all outputs 0, all blocks idle, rr_ptr=0, counters 0, muid_err=0. Asynchronous rst overrides everything, including mid-dispatch; in-flight results arriving after reset are ignored and raise no error.
- Per-block state machine, IDLE/BUSY:
  - IDLE -> BUSY when dispatched. Store the muid, clear the counter.
  - BUSY -> IDLE when a valid result has a muid equal to the stored muid.
  - BUSY -> IDLE when counter == TIMEOUT-1; pulse timeout_pulse[p] that same cycle.
  - A valid result whose muid mismatches: set muid_err, stay BUSY.
  - A valid result on an IDLE block: set muid_err.
- Dispatch, latency 1 (slc_in sampled at edge N appears on outputs at edge N+1):
  - Select the first IDLE block at index >= rr_ptr, wrapping modulo TOTAL_PTCALC_BLKS.
  - Drive slc_to_pt[sel] = slc_in with valid=1. All other slc_to_pt valid bits = 0; their payloads also 0.
  - rr_ptr <= sel+1, with wrap.
  - slcpipe_out = slc_in with valid=1, busy_out=0.
- No IDLE block:
  - slcpipe_out = slc_in with valid=1, busy_out=1; no slc_to_pt valid; rr_ptr unchanged.
- slc_in invalid: all valids 0, busy_out 0, rr_ptr unchanged.
- Simultaneous release and dispatch: eligibility uses the state before this edge. A block freed this cycle (by result or timeout) cannot be chosen until the next cycle.
- Simultaneous result and timeout on the same block: the result wins; no timeout pulse.
- Counter runs only while BUSY and saturates; it never wraps.
- blk_busy reflects the registered state.

Test Plan:
- Reset, then 3 valid candidates with muid 0x10, 0x11, 0x12 on consecutive cycles -> slc_to_pt[0], [1], [2] valid one cycle later respectively; blk_busy=3'b111; busy_out=0 each time.
- Fourth candidate (muid 0x13) with all blocks busy -> slcpipe_out valid, busy_out=1, no slc_to_pt valid. Then result muid 0x11 on block 1, followed next cycle by candidate 0x14 -> dispatched to block 1.
- Result on block 0 and a new candidate in the same cycle with only block 0 busy-releasing, others busy -> busy_out=1; the candidate after that goes to block 0.
- TIMEOUT=16: dispatch to block 2 with no result -> timeout_pulse[2] for exactly one cycle 16 cycles after dispatch; blk_busy[2]=0 afterwards; muid_err stays 0.
- Result with muid 0x55 on block 0 holding 0x10 -> muid_err=1, stays set, block 0 still busy. Result on idle block 1 -> muid_err stays 1.
- Assert rst low mid-stream with 2 blocks busy -> all outputs 0 asynchronously. After release, the first candidate goes to block 0.
